// File: rtl/io_debounce_pkg.sv
// io_debounce_pkg: board timing constants and shared types for the input conditioner.
// The default debounce window is derived from the board clock and the wanted debounce time.
package io_debounce_pkg;

  localparam int BOARD_CLK_HZ          = 50_000_000;
  localparam int DEBOUNCE_MS           = 1;
  localparam int DEFAULT_STABLE_CYCLES = (BOARD_CLK_HZ / 1000) * DEBOUNCE_MS;

  // Per-channel debounce state: IDLE when the input agrees with the output,
  // PENDING while a disagreement is being timed.
  typedef enum logic {
    CH_IDLE    = 1'b0,
    CH_PENDING = 1'b1
  } ch_state_e;

  // Counter width able to hold 0..stable_cycles without wrapping.
  function automatic int cnt_width(input int stable_cycles);
    return (stable_cycles < 1) ? 1 : $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/io_debounce_ch.sv
// io_debounce_ch: one input channel -- two-flop synchroniser, polarity fix,
// stable-time counter, debounced level and (with IO_DEBOUNCE_EDGE_EN) rise/fall pulses.
module io_debounce_ch
  import io_debounce_pkg::*;
#(
  parameter int   STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter logic INVERT_BIT    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  input  logic sample_en,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int            CW   = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          x;
  logic          terminal;
  logic          level_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  ch_state_e     state;
  ch_state_e     state_nx;

  // Synchroniser resets to the idle pin level so the normalised input starts at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= INVERT_BIT;
      s2 <= INVERT_BIT;
    end else begin
      s1 <= raw_in;
      s2 <= s1;
    end
  end

  assign x        = s2 ^ INVERT_BIT;
  assign terminal = sample_en && (cnt == LAST);

  // Debounce state, counter and output level registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CH_IDLE;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      level <= level_nx;
    end
  end

  // Any agreement restarts the window; disagreement counts on sample_en and flips at terminal count.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    level_nx = level;
    case (state)
      CH_IDLE, CH_PENDING: begin
        if (x == level) begin
          state_nx = CH_IDLE;
          cnt_nx   = '0;
        end else if (terminal) begin
          state_nx = CH_IDLE;
          cnt_nx   = '0;
          level_nx = x;
        end else begin
          state_nx = CH_PENDING;
          if (sample_en) begin
            cnt_nx = cnt + CW'(1);
          end
        end
      end
      default: begin
        state_nx = CH_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

`ifdef IO_DEBOUNCE_EDGE_EN
  // Edge pulses line up with the cycle the new level first appears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= level_nx & ~level;
      fall <= ~level_nx & level;
    end
  end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/io_debounce.sv
// io_debounce: N-channel input conditioner for buttons, switches and the Arduino reset.
// Define IO_DEBOUNCE_EDGE_EN to build the rise/fall/any_event pulse logic; otherwise they read 0.
module io_debounce
  import io_debounce_pkg::*;
#(
  parameter int                  CHANNELS      = 12,
  parameter int                  STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter logic [CHANNELS-1:0] INVERT        = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] raw_in,
  input  logic                sample_en,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_event
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    io_debounce_ch #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .INVERT_BIT    (INVERT[i])
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .raw_in    (raw_in[i]),
      .sample_en (sample_en),
      .level     (level[i]),
      .rise      (rise[i]),
      .fall      (fall[i])
    );
  end

`ifdef IO_DEBOUNCE_EDGE_EN
  // Summary strobe is an OR of already-registered pulses, so it never depends on raw_in directly.
  assign any_event = |{rise, fall};
`else
  assign any_event = 1'b0;
`endif

endmodule

// File: tb/tb_io_debounce.sv
// tb_io_debounce: scoreboard bench for io_debounce (4 channels, window of 4, channels 0/1 active-low).
module tb_io_debounce;

  localparam int            CH  = 4;
  localparam int            SC  = 4;
  localparam logic [CH-1:0] INV = 4'b0011;
`ifdef IO_DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          sample_en;
  logic [CH-1:0] raw_in;
  logic [CH-1:0] level;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic          any_event;

  typedef struct {
    logic [CH-1:0] level;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic          any;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  io_debounce #(
    .CHANNELS      (CH),
    .STABLE_CYCLES (SC),
    .INVERT        (INV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .raw_in    (raw_in),
    .sample_en (sample_en),
    .level     (level),
    .rise      (rise),
    .fall      (fall),
    .any_event (any_event)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "[TB] watchdog");
  end

  // Builds one expected output set; pulses are zero when edge logic is not built.
  function automatic exp_t mk(input logic [CH-1:0] lv, input logic [CH-1:0] r, input logic [CH-1:0] f);
    exp_t e;
    e.level = lv;
    e.rise  = EDGE_EN ? r : '0;
    e.fall  = EDGE_EN ? f : '0;
    e.any   = EDGE_EN ? |{r, f} : 1'b0;
    return e;
  endfunction

  task automatic test_reset();
    exp_t e;
    rst = 1'b1; sample_en = 1'b1; raw_in = 4'b0011;
    repeat (3) @(posedge clk);
    @(negedge clk);
    e = mk(4'b0000, 4'b0000, 4'b0000);
    checks++;
    if ({level, rise, fall, any_event} !== {e.level, e.rise, e.fall, e.any}) begin
      failures++;
      $display("[TB] FAIL reset_hold: got level=%b rise=%b fall=%b any=%b, want level=%b rise=%b fall=%b any=%b",
               level, rise, fall, any_event, e.level, e.rise, e.fall, e.any);
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int j = 1; j <= 20; j++) sb.push_back(mk(4'b0000, 4'b0000, 4'b0000));
    for (int j = 1; j <= 20; j++) begin
      @(posedge clk); @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({level, rise, fall, any_event} !== {e.level, e.rise, e.fall, e.any}) begin
        failures++;
        $display("[TB] FAIL reset_release cycle %0d: got level=%b rise=%b fall=%b any=%b, want level=%b rise=%b fall=%b any=%b",
                 j, level, rise, fall, any_event, e.level, e.rise, e.fall, e.any);
      end
    end
  endtask

  task automatic test_rise_ch2();
    exp_t e;
    @(posedge clk); #1 raw_in[2] = 1'b1;
    for (int j = 1; j <= 8; j++)
      sb.push_back(mk((j >= 6) ? 4'b0100 : 4'b0000, (j == 6) ? 4'b0100 : 4'b0000, 4'b0000));
    for (int j = 1; j <= 8; j++) begin
      @(posedge clk); @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({level, rise, fall, any_event} !== {e.level, e.rise, e.fall, e.any}) begin
        failures++;
        $display("[TB] FAIL rise_ch2 cycle %0d: got level=%b rise=%b fall=%b any=%b, want level=%b rise=%b fall=%b any=%b",
                 j, level, rise, fall, any_event, e.level, e.rise, e.fall, e.any);
      end
    end
  endtask

  task automatic test_bounce_ch0();
    exp_t e;
    // Three-cycle press is one short of the window and must be ignored.
    @(posedge clk); #1 raw_in[0] = 1'b0;
    for (int j = 1; j <= 10; j++) sb.push_back(mk(4'b0100, 4'b0000, 4'b0000));
    for (int j = 1; j <= 10; j++) begin
      @(posedge clk);
      if (j == 3) begin #1 raw_in[0] = 1'b1; end
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({level, rise, fall, any_event} !== {e.level, e.rise, e.fall, e.any}) begin
        failures++;
        $display("[TB] FAIL bounce_ch0 cycle %0d: got level=%b rise=%b fall=%b any=%b, want level=%b rise=%b fall=%b any=%b",
                 j, level, rise, fall, any_event, e.level, e.rise, e.fall, e.any);
      end
    end
    // A held press is accepted.
    @(posedge clk); #1 raw_in[0] = 1'b0;
    for (int j = 1; j <= 8; j++)
      sb.push_back(mk((j >= 6) ? 4'b0101 : 4'b0100, (j == 6) ? 4'b0001 : 4'b0000, 4'b0000));
    for (int j = 1; j <= 8; j++) begin
      @(posedge clk); @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({level, rise, fall, any_event} !== {e.level, e.rise, e.fall, e.any}) begin
        failures++;
        $display("[TB] FAIL press_ch0 cycle %0d: got level=%b rise=%b fall=%b any=%b, want level=%b rise=%b fall=%b any=%b",
                 j, level, rise, fall, any_event, e.level, e.rise, e.fall, e.any);
      end
    end
  endtask

  task automatic test_sample_en_fall();
    exp_t e;
    @(posedge clk); #1 raw_in[2] = 1'b0; sample_en = 1'b1;
    for (int j = 1; j <= 11; j++)
      sb.push_back(mk((j >= 9) ? 4'b0001 : 4'b0101, 4'b0000, (j == 9) ? 4'b0100 : 4'b0000));
    for (int j = 1; j <= 11; j++) begin
      @(posedge clk);
      #1 sample_en = ((j + 1) % 2 == 1);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({level, rise, fall, any_event} !== {e.level, e.rise, e.fall, e.any}) begin
        failures++;
        $display("[TB] FAIL sample_en_fall cycle %0d: got level=%b rise=%b fall=%b any=%b, want level=%b rise=%b fall=%b any=%b",
                 j, level, rise, fall, any_event, e.level, e.rise, e.fall, e.any);
      end
    end
    @(posedge clk); #1 sample_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    @(posedge clk); #1 raw_in[3:2] = 2'b11;
    for (int j = 1; j <= 8; j++)
      sb.push_back(mk((j >= 6) ? 4'b1101 : 4'b0001, (j == 6) ? 4'b1100 : 4'b0000, 4'b0000));
    for (int j = 1; j <= 8; j++) begin
      @(posedge clk); @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({level, rise, fall, any_event} !== {e.level, e.rise, e.fall, e.any}) begin
        failures++;
        $display("[TB] FAIL dual_rise cycle %0d: got level=%b rise=%b fall=%b any=%b, want level=%b rise=%b fall=%b any=%b",
                 j, level, rise, fall, any_event, e.level, e.rise, e.fall, e.any);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    exp_t e;
    // Channel 1 pressed, reset lands one edge before it would flip, then the window restarts.
    @(posedge clk); #1 raw_in[1] = 1'b0;
    for (int j = 1; j <= 15; j++) begin
      if (j <= 4)       sb.push_back(mk(4'b1101, 4'b0000, 4'b0000));
      else if (j <= 12) sb.push_back(mk(4'b0000, 4'b0000, 4'b0000));
      else if (j == 13) sb.push_back(mk(4'b1111, 4'b1111, 4'b0000));
      else              sb.push_back(mk(4'b1111, 4'b0000, 4'b0000));
    end
    for (int j = 1; j <= 15; j++) begin
      @(posedge clk);
      if (j == 5) begin #1 rst = 1'b1; end
      if (j == 7) begin #1 rst = 1'b0; end
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({level, rise, fall, any_event} !== {e.level, e.rise, e.fall, e.any}) begin
        failures++;
        $display("[TB] FAIL reset_mid_count cycle %0d: got level=%b rise=%b fall=%b any=%b, want level=%b rise=%b fall=%b any=%b",
                 j, level, rise, fall, any_event, e.level, e.rise, e.fall, e.any);
      end
    end
  endtask

  initial begin
    $display("[TB] io_debounce bench start, edge logic built = %0d", EDGE_EN);
    test_reset();
    test_rise_ch2();
    test_bounce_ch0();
    test_sample_en_fall();
    test_back_to_back();
    test_reset_mid_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
